// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBWI/TLBR/TLBP: latches the CP0 operands, stalls MEM while it
// writes, reads or scans the single-ported entry array, then pulses a commit.
module tlb_op_ctrl #(
  parameter int TLB_ENTRIES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           op_valid,
  input  logic [2:0]                     op_type,
  input  logic                           flush,
  input  logic [31:0]                    entry_hi_in,
  input  logic [31:0]                    page_mask_in,
  input  logic [31:0]                    entry_lo0_in,
  input  logic [31:0]                    entry_lo1_in,
  input  logic [31:0]                    index_in,
  output logic                           stall,
  output logic                           done,
  output logic [2:0]                     tlb_type_out,
  output logic [31:0]                    index_out,
  output logic [31:0]                    entry_hi_out,
  output logic [31:0]                    page_mask_out,
  output logic [31:0]                    entry_lo0_out,
  output logic [31:0]                    entry_lo1_out,
  output logic [$clog2(TLB_ENTRIES)-1:0] arr_addr,
  output logic                           arr_we,
  output logic [89:0]                    arr_wdata,
  input  logic [89:0]                    arr_rdata
);
  localparam int IDX_W = $clog2(TLB_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRIES - 1);

  typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, P_SCAN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [89:0]      entry_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [2:0]       type_reg;
  logic [IDX_W-1:0] cnt_reg;
  logic [IDX_W-1:0] cmp_idx_reg;
  logic             cmp_valid_reg;

  logic        accept;
  logic [89:0] entry_in;
  logic        hit;
  logic        scan_last;
  logic        unused_bits;

  assign accept = op_valid & ~flush & (|op_type);

  // CP0 words packed straight into array format; TLBP reuses the vpn2/asid fields.
  assign entry_in = {entry_hi_in[31:13], entry_hi_in[7:0], page_mask_in[24:13],
                     entry_lo0_in[0] & entry_lo1_in[0],
                     entry_lo0_in[25:1], entry_lo1_in[25:1]};

  assign hit = (((arr_rdata[89:71] ^ entry_reg[89:71]) & ~{7'b0, arr_rdata[62:51]}) == 19'd0)
             && (arr_rdata[50] || (arr_rdata[70:63] == entry_reg[70:63]));
  assign scan_last = (cmp_idx_reg == LAST_IDX);

  assign unused_bits = ^{entry_hi_in[12:8], page_mask_in[31:25], page_mask_in[12:0],
                         entry_lo0_in[31:26], entry_lo1_in[31:26], index_in[31:IDX_W]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      entry_reg     <= '0;
      idx_reg       <= '0;
      type_reg      <= '0;
      cnt_reg       <= '0;
      cmp_idx_reg   <= '0;
      cmp_valid_reg <= 1'b0;
      index_out     <= '0;
      entry_hi_out  <= '0;
      page_mask_out <= '0;
      entry_lo0_out <= '0;
      entry_lo1_out <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && accept) begin
        entry_reg <= entry_in;
        idx_reg   <= index_in[IDX_W-1:0];
        type_reg  <= op_type[2] ? 3'b100 : (op_type[1] ? 3'b010 : 3'b001);
      end
      // Scan pipeline: address issued one cycle, its entry compared the next.
      if (state_reg == P_SCAN) begin
        cmp_valid_reg <= 1'b1;
        cmp_idx_reg   <= cnt_reg;
        if (cnt_reg != LAST_IDX) cnt_reg <= cnt_reg + 1'b1;
      end else begin
        cnt_reg       <= '0;
        cmp_valid_reg <= 1'b0;
      end
      if (!flush) begin
        if (state_reg == RD_WAIT) begin
          entry_hi_out  <= {arr_rdata[89:71], 5'b0, arr_rdata[70:63]};
          page_mask_out <= {7'b0, arr_rdata[62:51], 13'b0};
          entry_lo0_out <= {6'b0, arr_rdata[49:25], arr_rdata[50]};
          entry_lo1_out <= {6'b0, arr_rdata[24:0], arr_rdata[50]};
        end
        if (state_reg == P_SCAN && cmp_valid_reg) begin
          if (hit)            index_out <= {{(32-IDX_W){1'b0}}, cmp_idx_reg};
          else if (scan_last) index_out <= 32'h8000_0000;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (op_type[2])      state_next = WRITE;
          else if (op_type[1]) state_next = RD_REQ;
          else                 state_next = P_SCAN;
        end
      end
      WRITE:   state_next = flush ? IDLE : DONE;
      RD_REQ:  state_next = flush ? IDLE : RD_WAIT;
      RD_WAIT: state_next = flush ? IDLE : DONE;
      P_SCAN: begin
        if (flush)                                       state_next = IDLE;
        else if (cmp_valid_reg && (hit || scan_last))    state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall        = rst & (((state_reg == IDLE) & accept)
                          | ((state_reg != IDLE) & (state_reg != DONE)));
    done         = (state_reg == DONE);
    tlb_type_out = (state_reg == DONE) ? type_reg : 3'b000;
    arr_we       = (state_reg == WRITE) & ~flush & rst;
    arr_wdata    = entry_reg;
    arr_addr     = '0;
    case (state_reg)
      WRITE, RD_REQ, RD_WAIT: arr_addr = idx_reg;
      P_SCAN:                 arr_addr = cnt_reg;
      default:                arr_addr = '0;
    endcase
  end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Multi-cycle sequencer for the MEM-stage TLB management instructions (TLBWI, TLBR, TLBP). It sits between the MEM stage, the CP0 register file and a single-ported TLB entry array. It latches the CP0 EntryHi/PageMask/EntryLo0/EntryLo1/Index values and stalls the pipeline while it writes, reads or scans the array. On completion it returns a one-cycle commit pulse with the result words, which CP0 loads into Index/EntryHi/PageMask/EntryLo0/EntryLo1.

## Interface
Parameters:
- TLB_ENTRIES, 16, number of array entries (power of 2, 2..64); IDX_W = log2(TLB_ENTRIES), localparam.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset (0 = reset).
- op_valid  in  1  TLB instruction present in MEM.
- op_type  in  3  one-hot {tlbwi, tlbr, tlbp}; same encoding as CP0 tlb_type.
- flush  in  1  exception/pipeline flush; aborts the operation.
- entry_hi_in, page_mask_in, entry_lo0_in, entry_lo1_in, index_in  in  32 each  current CP0 values.
- stall  out  1  holds the pipeline.
- done  out  1  one-cycle completion pulse.
- tlb_type_out  out  3  one-hot commit to CP0, valid only with done; 0 otherwise.
- index_out, entry_hi_out, page_mask_out, entry_lo0_out, entry_lo1_out  out  32 each  result words, registered.
- arr_addr  out  IDX_W  array entry address.
- arr_we  out  1  array write enable.
- arr_wdata  out  90  packed entry to write.
- arr_rdata  in  90  packed entry read; valid 1 cycle after arr_addr.

Entry packing, MSB first: vpn2[18:0], asid[7:0], mask[11:0], g, pfn0[19:0], c0[2:0], d0, v0, pfn1[19:0], c1[2:0], d1, v1.

## Operation
- States: IDLE, WRITE, RD_REQ, RD_WAIT, P_SCAN, DONE.
- IDLE: accept when op_valid & ~flush. Latch all five CP0 inputs and op_type. Next state: tlbwi→WRITE, tlbr→RD_REQ, tlbp→P_SCAN with scan counter = 0. op_type of 0 is ignored.
- WRITE:
  - arr_addr = index[IDX_W-1:0]; arr_we = ~flush.
  - arr_wdata fields: vpn2 = hi[31:13], asid = hi[7:0], mask = pm[24:13], g = lo0[0] & lo1[0], pfnX = loX[25:6], cX = loX[5:3], dX = loX[2], vX = loX[1].
  - Next state: DONE.
- RD_REQ: arr_addr = latched index → RD_WAIT. RD_WAIT: capture arr_rdata into the outputs → DONE.
  - entry_hi_out = {vpn2, 5'b0, asid}.
  - page_mask_out = {7'b0, mask, 13'b0}.
  - entry_loX_out = {6'b0, pfnX, cX, dX, vX, g}.
- P_SCAN:
  - Issue arr_addr = counter each cycle; compare the entry returned the following cycle (pipelined).
  - Match: (vpn2 & ~mask) == (hi[31:13] & ~mask), and (g | asid == hi[7:0]).
  - First match, lowest index: index_out = {1'b0, 0..., idx} → DONE; remaining entries are not examined. Multiple matches are not an error.
  - No match after entry TLB_ENTRIES-1 compares: index_out = 32'h8000_0000 → DONE.
  - Counter does not wrap; issuing stops at TLB_ENTRIES-1.
- DONE: done = 1; tlb_type_out = latched op_type; stall = 0 → IDLE. op_valid is ignored in DONE.
- Only the outputs belonging to the op are updated: TLBP updates index_out, TLBR updates the other four, TLBWI updates none. All outputs hold otherwise.
- flush in any state other than IDLE/DONE: return to IDLE next cycle, no done, no output update. A flush during WRITE suppresses arr_we in that same cycle.
- stall = rst & ((state==IDLE & op_valid & |op_type & ~flush) | state ∉ {IDLE, DONE}).
- arr_we = 0 outside WRITE; arr_addr = 0 in IDLE/DONE.

## Timing
- Reset: state IDLE, counter 0, all result outputs 0, done 0, tlb_type_out 0, arr_we 0, arr_addr 0, stall 0. Reset mid-operation abandons the op with no write.
- Accept in cycle T.
- TLBWI: write at T+1, done at T+2.
- TLBR: read address at T+1, data at T+2, done at T+3.
- TLBP: address i issued at T+1+i; hit on i → done at T+3+i; miss → done at T+2+TLB_ENTRIES.
- Pipeline resumes at the end of the done cycle; the next op can be accepted at done+1.

## Test plan
- Reset held 3 cycles with op_valid=1 → stall=0, done=0, all outputs 0; after release, IDLE accepts the op.
- TLBWI: index=5, hi=32'h1234_6042, lo0=32'h0000_0147, lo1=32'h0000_0287 → arr_we at T+1, addr 5, g=1. A following TLBR of index 5 → entry_hi_out=32'h1234_6042, entry_lo0_out=32'h0000_0147, entry_lo1_out=32'h0000_0287, tlb_type_out=3'b010 at T+3.
- TLBP with the matching entry at index 3 and a duplicate at 9 → index_out=32'h0000_0003, done at T+6, tlb_type_out=3'b001.
- TLBP with no match (16 entries) → index_out=32'h8000_0000, done at T+18, stall high T..T+17.
- TLBP where the entry has a different ASID but g=1, and the entry mask=12'hFFF differs in the low vpn2 bits → hit. Same entry with g=0 and a different ASID → miss.
- flush asserted at T+4 of a TLBP scan, and in the WRITE cycle of a TLBWI → no done, arr_we stays 0, outputs unchanged, a new op is accepted the next cycle.
